// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and constants for the unified memory port arbiter
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } arb_owner_t;

  localparam logic RD = 1'b1;
  localparam logic WR = 1'b0;

endpackage

// File: rtl/mem_arb_pick.sv
// rtl/mem_arb_pick.sv - owner selection; MEM_ARB_RR_EN selects round-robin on ties
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic       if_req,
  input  logic       d_req,
  input  arb_owner_t last_owner,
  output arb_owner_t owner
);

`ifdef MEM_ARB_RR_EN
  // On a tie the requester that did not own the port last time wins
  always_comb begin
    owner = OWN_IF;
    if (if_req && d_req) begin
      owner = (last_owner == OWN_D) ? OWN_IF : OWN_D;
    end else if (d_req) begin
      owner = OWN_D;
    end
  end
`else
  // Data access is mid-instruction, so it always beats fetch
  logic unused_last_owner;
  assign unused_last_owner = last_owner;

  always_comb begin
    owner = OWN_IF;
    if (d_req) begin
      owner = OWN_D;
    end
  end
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one memory port between fetch and data; MEM_ARB_RR_EN enables round-robin
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_rd_wr,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_rd_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam logic [3:0] LAST_CNT = 4'(MEM_LAT - 1);

  arb_state_t state;
  arb_state_t next_state;
  arb_owner_t owner;
  arb_owner_t pick_owner;
  arb_owner_t last_owner;
  logic [3:0] cnt;
  logic       dir;
  logic       pick_dir;
  logic       start;
  logic       last_beat;

  assign start     = (state == IDLE) && (if_req || d_req);
  assign last_beat = (state == ACCESS) && (cnt == LAST_CNT);
  assign pick_dir  = (pick_owner == OWN_D) ? d_rd_wr : RD;

  mem_arb_pick u_pick (
    .if_req     (if_req),
    .d_req      (d_req),
    .last_owner (last_owner),
    .owner      (pick_owner)
  );

`ifdef MEM_ARB_RR_EN
  // Remember who was granted last so a tie goes to the other requester
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_owner <= OWN_IF;
    end else if (start) begin
      last_owner <= pick_owner;
    end
  end
`else
  assign last_owner = OWN_IF;
`endif

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic: IDLE -> ACCESS for MEM_LAT cycles -> DONE -> IDLE
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (if_req || d_req) next_state = ACCESS;
      ACCESS:  if (cnt == LAST_CNT) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Latency counter restarts at every grant and advances through ACCESS
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (start) begin
      cnt <= '0;
    end else if (state == ACCESS) begin
      cnt <= cnt + 4'd1;
    end
  end

  // Capture owner, direction, word-aligned address and store data at grant
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      owner     <= OWN_IF;
      dir       <= RD;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else if (start) begin
      owner <= pick_owner;
      dir   <= pick_dir;
      if (pick_owner == OWN_D) begin
        mem_addr  <= {d_addr[ADDR_W-1:2], 2'b00};
        mem_wdata <= d_wdata;
      end else begin
        mem_addr  <= {if_addr[ADDR_W-1:2], 2'b00};
      end
    end
  end

  // Registered outputs, computed from the state being entered
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      if_gnt    <= 1'b0;
      d_gnt     <= 1'b0;
      if_rvalid <= 1'b0;
      d_rvalid  <= 1'b0;
      if_rdata  <= '0;
      d_rdata   <= '0;
      mem_en    <= 1'b0;
      mem_rd_wr <= RD;
      busy      <= 1'b0;
    end else begin
      if_gnt    <= start && (pick_owner == OWN_IF);
      d_gnt     <= start && (pick_owner == OWN_D);
      if_rvalid <= last_beat && (owner == OWN_IF);
      d_rvalid  <= last_beat && (owner == OWN_D);
      mem_en    <= (next_state == ACCESS);
      mem_rd_wr <= (next_state == ACCESS) ? (start ? pick_dir : dir) : RD;
      busy      <= (next_state != IDLE);
      if (last_beat && dir == RD) begin
        if (owner == OWN_IF) begin
          if_rdata <= mem_rdata;
        end else begin
          d_rdata <= mem_rdata;
        end
      end
    end
  end

endmodule
